// File: rtl/time_display.sv
`default_nettype none
// ============================================================================
// Module  : time_display
// Brief   : Two-digit 7-segment driver for a 0..63 s countdown with blink on
//           finish; optional leading-zero blanking via TIME_DISPLAY_LZ_BLANK_EN.
// Rev     : 1.0
// ============================================================================
module time_display #(
  parameter logic [15:0] SCAN_DIV   = 16'd1000,
  parameter int          BLINK_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cnttime,
  input  logic       over,
  output logic [7:0] seg,
  output logic [1:0] dig,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [5:0]      r_last_val, w_last_nxt;
  logic [5:0]      r_work, w_work_nxt;
  logic [3:0]      r_tens, w_tens_nxt;
  logic [3:0]      r_ones, w_ones_nxt;
  logic [3:0]      r_disp_t, w_disp_t_nxt;
  logic [3:0]      r_disp_o, w_disp_o_nxt;
  logic [15:0]     r_scan;
  logic [BLINK_BITS-1:0] r_blink;
  logic [1:0]      r_dig, w_dig_nxt;
  logic [7:0]      r_seg, w_seg_nxt;
  logic [3:0]      w_digit;
  logic            w_tick;

  function automatic logic [7:0] f_seg7(input logic [3:0] d);
    case (d)
      4'd0:    f_seg7 = 8'h3F;
      4'd1:    f_seg7 = 8'h06;
      4'd2:    f_seg7 = 8'h5B;
      4'd3:    f_seg7 = 8'h4F;
      4'd4:    f_seg7 = 8'h66;
      4'd5:    f_seg7 = 8'h6D;
      4'd6:    f_seg7 = 8'h7D;
      4'd7:    f_seg7 = 8'h07;
      4'd8:    f_seg7 = 8'h7F;
      4'd9:    f_seg7 = 8'h6F;
      default: f_seg7 = 8'h00;
    endcase
  endfunction

  // Repeated-subtraction binary-to-BCD; display registers only move in DONE.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last_val;
    w_work_nxt   = r_work;
    w_tens_nxt   = r_tens;
    w_ones_nxt   = r_ones;
    w_disp_t_nxt = r_disp_t;
    w_disp_o_nxt = r_disp_o;
    case (r_state)
      IDLE: begin
        if (cnttime != r_last_val) begin
          w_last_nxt  = cnttime;
          w_work_nxt  = cnttime;
          w_tens_nxt  = 4'd0;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        if (r_work >= 6'd10) begin
          w_work_nxt = r_work - 6'd10;
          w_tens_nxt = r_tens + 4'd1;
        end else begin
          w_ones_nxt  = r_work[3:0];
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_disp_t_nxt = r_tens;
        w_disp_o_nxt = r_ones;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_val <= 6'd0;
      r_work     <= 6'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_disp_t   <= 4'd0;
      r_disp_o   <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_val <= w_last_nxt;
      r_work     <= w_work_nxt;
      r_tens     <= w_tens_nxt;
      r_ones     <= w_ones_nxt;
      r_disp_t   <= w_disp_t_nxt;
      r_disp_o   <= w_disp_o_nxt;
    end
  end

  assign w_tick    = (r_scan == SCAN_DIV - 16'd1);
  assign w_dig_nxt = {r_dig[0], r_dig[1]};
  assign w_digit   = w_dig_nxt[1] ? r_disp_t : r_disp_o;

  // Pattern is chosen for the digit about to be selected, so seg and dig move together.
  always_comb begin
    w_seg_nxt = f_seg7(w_digit);
    if (over && r_blink[BLINK_BITS-1]) begin
      w_seg_nxt = 8'h00;
    end
`ifdef TIME_DISPLAY_LZ_BLANK_EN
    else if (w_dig_nxt[1] && (r_disp_t == 4'd0)) begin
      w_seg_nxt = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan  <= 16'd0;
      r_blink <= '0;
      r_dig   <= 2'b01;
      r_seg   <= 8'h00;
    end else begin
      r_scan <= w_tick ? 16'd0 : r_scan + 16'd1;
      if (!over) begin
        r_blink <= '0;
      end else if (w_tick) begin
        r_blink <= r_blink + 1'b1;
      end
      if (w_tick) begin
        r_dig <= w_dig_nxt;
        r_seg <= w_seg_nxt;
      end
    end
  end

  assign seg  = r_seg;
  assign dig  = r_dig;
  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_time_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_time_display
// Brief   : Self-checking bench for time_display against a latency/arithmetic model.
// Rev     : 1.0
// ============================================================================
module tb_time_display;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_BITS = 2;
  localparam int BLINK_MOD  = 1 << BLINK_BITS;

`ifdef TIME_DISPLAY_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] cnttime = 6'd60;
  logic       over = 1'b0;
  logic [7:0] seg;
  logic [1:0] dig;
  logic       busy;

  always #5 clk = ~clk;

  time_display #(
    .SCAN_DIV  (16'(SCAN_DIV)),
    .BLINK_BITS(BLINK_BITS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cnttime(cnttime),
    .over   (over),
    .seg    (seg),
    .dig    (dig),
    .busy   (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  logic [7:0] pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Model: a captured value becomes visible value/10 + 2 cycles later;
  // digits alternate every SCAN_DIV cycles, blink phase counts ticks.
  int         m_last = 0, m_cnt = 0, m_pend = 0, m_dt = 0, m_do = 0;
  int         m_phase = 0, m_blink = 0;
  logic [1:0] m_dig = 2'b01;
  logic [7:0] m_seg = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last = 0; m_cnt = 0; m_pend = 0; m_dt = 0; m_do = 0;
      m_phase = 0; m_blink = 0; m_dig = 2'b01; m_seg = 8'h00;
    end else begin
      if (m_phase == SCAN_DIV - 1) begin
        m_phase = 0;
        m_dig   = (m_dig == 2'b01) ? 2'b10 : 2'b01;
        if (over && m_blink >= BLINK_MOD / 2) m_seg = 8'h00;
        else if (m_dig == 2'b10) m_seg = (LZ && m_dt == 0) ? 8'h00 : pat[m_dt];
        else m_seg = pat[m_do];
        if (over) m_blink = (m_blink + 1) % BLINK_MOD;
      end else begin
        m_phase = m_phase + 1;
      end
      if (!over) m_blink = 0;
      if (m_cnt == 0) begin
        if (int'(cnttime) != m_last) begin
          m_last = int'(cnttime);
          m_pend = int'(cnttime);
          m_cnt  = m_pend / 10 + 2;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_dt = m_pend / 10;
          m_do = m_pend % 10;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("seg_vs_model", int'(seg), int'(m_seg));
    check("dig_vs_model", int'(dig), int'(m_dig));
    check("busy_vs_model", int'(busy), (m_cnt != 0) ? 1 : 0);
  end

  task automatic count_busy(input string name, input int exp);
    int n = 0;
    for (int k = 0; k < 5 && !busy; k++) @(negedge clk);
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    check(name, int'(busy), 0);
  endtask

  task automatic sample_digits(output logic [7:0] t, output logic [7:0] o);
    t = 8'hEE;
    o = 8'hEE;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk);
      if (dig == 2'b10) t = seg;
      if (dig == 2'b01) o = seg;
    end
  endtask

  task automatic count_ones_ticks(input int nticks, output int blank, output int lit);
    logic [1:0] prev;
    int ticks = 0;
    blank = 0;
    lit   = 0;
    for (int k = 0; k < 100 && ticks < nticks; k++) begin
      prev = dig;
      @(negedge clk);
      if (dig != prev) begin
        ticks++;
        if (dig == 2'b01) begin
          if (seg == 8'h00) blank++;
          else if (seg == 8'h3F) lit++;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] t, o;
    int blank, lit;

    repeat (3) @(negedge clk);
    check("reset_seg", int'(seg), 8'h00);
    check("reset_dig", int'(dig), 2'b01);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;

    count_busy("busy_len_60", 8);
    sample_digits(t, o);
    check("disp60_tens", int'(t), 8'h7D);
    check("disp60_ones", int'(o), 8'h3F);

    cnttime = 6'd59;
    count_busy("busy_len_59", 7);
    sample_digits(t, o);
    check("disp59_tens", int'(t), 8'h6D);
    check("disp59_ones", int'(o), 8'h6F);

    cnttime = 6'd58;
    @(negedge clk);
    cnttime = 6'd57;
    wait_idle("idle_after_58");
    @(negedge clk);
    wait_idle("idle_after_57");
    sample_digits(t, o);
    check("disp57_tens", int'(t), 8'h6D);
    check("disp57_ones", int'(o), 8'h07);

    cnttime = 6'd0;
    count_busy("busy_len_0", 2);
    repeat (2 * SCAN_DIV) @(negedge clk);
    over = 1'b1;
    count_ones_ticks(8, blank, lit);
    check("blink_blank_ticks", blank, 2);
    check("blink_lit_ticks", lit, 2);
    over = 1'b0;
    count_ones_ticks(8, blank, lit);
    check("steady_lit_ticks", lit, 4);

    cnttime = 6'd45;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midconv_rst_seg", int'(seg), 8'h00);
    check("midconv_rst_dig", int'(dig), 2'b01);
    check("midconv_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    count_busy("busy_len_45", 6);
    sample_digits(t, o);
    check("disp45_tens", int'(t), 8'h66);
    check("disp45_ones", int'(o), 8'h6D);

    cnttime = 6'd7;
    count_busy("busy_len_7", 2);
    sample_digits(t, o);
    check("disp07_tens", int'(t), LZ ? 8'h00 : 8'h3F);
    check("disp07_ones", int'(o), 8'h07);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) cnttime = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 49) == 0) over = ~over;
    end
    rst  = 1'b0;
    over = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd1000; clk cycles per digit-scan tick (>=2).
REQ-002 SHALL have parameter BLINK_BITS, default 4; width of the blink counter, which counts scan ticks.
REQ-003 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cnttime  input  6  remaining seconds from the upstream countdown, unsigned 0..63.
REQ-006 SHALL have port over  input  1  countdown-finished flag, level.
REQ-007 SHALL have port seg  output  8  registered segment pattern; bit0..6 = a..g, bit7 = DP; 1 = lit (common cathode).
REQ-008 SHALL have port dig  output  2  registered one-hot digit select, active-high; 2'b01 = ones digit, 2'b10 = tens digit.
REQ-009 SHALL have port busy  output  1  high while the binary-to-BCD conversion FSM is not in IDLE.

Function
REQ-010 SHALL keep a register last_val holding the last captured cnttime.
REQ-011 SHALL run the FSM states IDLE, CONV and DONE.
REQ-012 SHALL, in IDLE when cnttime != last_val, capture cnttime into last_val and into a working register, clear tens to 0, and move to CONV in the same cycle.
REQ-013 SHALL, in CONV each cycle: if work >= 10, subtract 10 from work and increment tens; else set ones = work[3:0] and move to DONE.
REQ-014 SHALL, in DONE, copy tens/ones into the display registers disp_t/disp_o in one cycle and return to IDLE.
REQ-015 SHALL give a conversion latency from capture to display-register update of (tens+2) cycles; max 8 for input 63.
REQ-016 SHALL ignore changes of cnttime while busy; the IDLE compare against last_val picks up the newest value afterwards, so no update is lost permanently.
REQ-017 SHALL update disp_t/disp_o only in DONE, so the display never shows partial results.
REQ-018 SHALL have a scan counter count 0..SCAN_DIV-1 and wrap; the wrap cycle is the scan tick.
REQ-019 SHALL, on each scan tick, toggle dig between 2'b01 and 2'b10 and load seg with the pattern for the newly selected digit, both in the same clock edge.
REQ-020 SHALL use these digit patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); DP always 0.
REQ-021 SHALL hold the blink counter at 0 while over=0; while over=1 it increments on each scan tick and wraps.
REQ-022 SHALL load seg=8'h00 on scan ticks while over=1 and the blink counter MSB=1, and the normal pattern when the MSB=0.
REQ-023 SHALL, when over falls, clear the blink counter the next cycle and resume normal display at the next scan tick.
REQ-024 SHALL, if capture and scan tick coincide, use the old disp_t/disp_o for that tick.

Reset
REQ-025 SHALL, on rst, asynchronously set: state=IDLE, last_val=0, work=0, tens=0, ones=0, disp_t=0, disp_o=0, scan counter=0, blink counter=0, dig=2'b01, seg=8'h00, busy=0.
REQ-026 SHALL, on rst asserted mid-conversion, abandon the conversion.
REQ-027 SHALL, after release, convert cnttime (upstream resets to 60) because 60 != last_val=0.
REQ-028 SHALL keep every output constant while rst is high.

Configuration
REQ-029 SHALL support the macro TIME_DISPLAY_LZ_BLANK_EN for leading-zero blanking.
REQ-030 SHALL, when TIME_DISPLAY_LZ_BLANK_EN is defined, load seg=8'h00 for the tens digit when disp_t=0; the ones digit is always shown.
REQ-031 SHALL, when TIME_DISPLAY_LZ_BLANK_EN is undefined, show the tens digit 0 as 3F.

Verification (SCAN_DIV=4, BLINK_BITS=2)
REQ-032 SHALL cover: reset release with cnttime=60 -> busy for 8 cycles; tens digit shows 7D and ones digit shows 3F on alternate ticks every 4 cycles.
REQ-033 SHALL cover: cnttime 60->59 -> busy 7 cycles; display becomes 6D (tens) / 6F (ones); no intermediate value ever appears on seg.
REQ-034 SHALL cover: cnttime changes 59->58->57 on consecutive cycles during busy -> final display 5/7 (6D/07), with no stale result after the second conversion.
REQ-035 SHALL cover: cnttime=0, over=1 -> seg alternates 3F for 2 ticks, 00 for 2 ticks; over=0 -> steady 3F.
REQ-036 SHALL cover: rst pulse during CONV of 45 -> all reset values immediately; afterwards cnttime=45 converts to 66/6D.
REQ-037 SHALL cover: cnttime=7 with TIME_DISPLAY_LZ_BLANK_EN defined -> tens digit seg=00, ones digit 07; without the macro -> tens digit 3F.
